// File: rtl/rf2_masked_bypass_ram_if.sv
// Request/response bundle for the 1R1W masked register-file RAM.
interface rf2_masked_bypass_ram_if #(
  parameter int unsigned DATAW = 128,
  parameter int unsigned ADDRW = 5
);
  logic             init_done;
  logic             read_en;
  logic [ADDRW-1:0] read_addr;
  logic             read_valid;
  logic [DATAW-1:0] read_data;
  logic             write_en;
  logic [ADDRW-1:0] write_addr;
  logic [DATAW-1:0] write_mask;
  logic [DATAW-1:0] write_data;

  // Requester side.
  modport master (
    input  init_done, read_valid, read_data,
    output read_en, read_addr, write_en, write_addr, write_mask, write_data
  );

  // RAM side.
  modport slave (
    output init_done, read_valid, read_data,
    input  read_en, read_addr, write_en, write_addr, write_mask, write_data
  );
endinterface

// File: rtl/rf2_masked_bypass_ram.sv
// Parametrised 1R1W register-file RAM: per-bit write mask, registered read,
// optional write-to-read bypass on address collision, and a post-reset clear sweep.
module rf2_masked_bypass_ram #(
  parameter int unsigned      DATAW       = 128,
  parameter int unsigned      SIZE        = 32,
  parameter int unsigned      ADDRW       = $clog2(SIZE),
  parameter bit               BYPASS      = 1'b1,
  parameter bit               INIT_ENABLE = 1'b1,
  parameter logic [DATAW-1:0] INIT_VALUE  = '0
) (
  input logic                   clk,
  input logic                   reset_n,
  rf2_masked_bypass_ram_if.slave bus_io
);

  typedef enum logic {StInit, StReady} state_e;

  state_e           state_q, state_d;
  logic [ADDRW-1:0] init_cnt_q, init_cnt_d;
  logic             init_done_q, init_done_d;
  logic             read_valid_q, read_valid_d;
  logic [DATAW-1:0] read_data_q, read_data_d;
  logic             init_wr;

  logic [DATAW-1:0] mem_q [SIZE];

  logic             wr_in_range, rd_in_range;
  logic             wr_ok, rd_ok;
  logic [DATAW-1:0] wr_old, wr_merged, rd_old, rd_val;

  // Init sequencer next state: one entry per cycle, then park in StReady.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    init_wr    = 1'b0;
    case (state_q)
      StInit: begin
        init_wr = 1'b1;
        if (32'(init_cnt_q) == SIZE - 1) begin
          state_d    = StReady;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + ADDRW'(1);
        end
      end
      default: ;
    endcase
    init_done_d = (state_d == StReady);
  end

  // Request datapath: acceptance, masked merge, bypass selection and read hold.
  always_comb begin
    // Out-of-range only exists when SIZE is not a power of two.
    wr_in_range = 32'(bus_io.write_addr) < SIZE;
    rd_in_range = 32'(bus_io.read_addr) < SIZE;
    wr_ok       = init_done_q && bus_io.write_en && wr_in_range;
    rd_ok       = init_done_q && bus_io.read_en;

    wr_old = '0;
    if (wr_in_range) wr_old = mem_q[bus_io.write_addr];
    wr_merged = (wr_old & ~bus_io.write_mask) | (bus_io.write_data & bus_io.write_mask);

    rd_old = '0;
    if (rd_in_range) rd_old = mem_q[bus_io.read_addr];
    rd_val = rd_old;
    if (BYPASS && wr_ok && (bus_io.write_addr == bus_io.read_addr)) rd_val = wr_merged;

    read_valid_d = rd_ok;
    read_data_d  = rd_ok ? rd_val : read_data_q;
  end

  // Control and read-port registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= INIT_ENABLE ? StInit : StReady;
      init_cnt_q   <= '0;
      init_done_q  <= 1'b0;
      read_valid_q <= 1'b0;
      read_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      init_done_q  <= init_done_d;
      read_valid_q <= read_valid_d;
      read_data_q  <= read_data_d;
    end
  end

  // Storage array; not reset, cleared by the sweep instead.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (init_wr) begin
        mem_q[init_cnt_q] <= INIT_VALUE;
      end else if (wr_ok) begin
        mem_q[bus_io.write_addr] <= wr_merged;
      end
    end
  end

  assign bus_io.init_done  = init_done_q;
  assign bus_io.read_valid = read_valid_q;
  assign bus_io.read_data  = read_data_q;

endmodule

// File: tb/tb_rf2_masked_bypass_ram.sv
// Bench for rf2_masked_bypass_ram: two instances share one stimulus stream,
// A = 32 entries with bypass, B = 20 entries without bypass and a non-zero init value.
module tb_rf2_masked_bypass_ram;

  localparam logic [127:0] InitB = {4{32'hA5A5_0F0F}};
  localparam logic [127:0] Ones  = {128{1'b1}};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic         read_en_s = 1'b0;
  logic [4:0]   read_addr_s = '0;
  logic         write_en_s = 1'b0;
  logic [4:0]   write_addr_s = '0;
  logic [127:0] write_mask_s = '0;
  logic [127:0] write_data_s = '0;

  rf2_masked_bypass_ram_if #(.DATAW(128), .ADDRW(5)) if_a ();
  rf2_masked_bypass_ram_if #(.DATAW(128), .ADDRW(5)) if_b ();

  assign if_a.read_en    = read_en_s;
  assign if_a.read_addr  = read_addr_s;
  assign if_a.write_en   = write_en_s;
  assign if_a.write_addr = write_addr_s;
  assign if_a.write_mask = write_mask_s;
  assign if_a.write_data = write_data_s;
  assign if_b.read_en    = read_en_s;
  assign if_b.read_addr  = read_addr_s;
  assign if_b.write_en   = write_en_s;
  assign if_b.write_addr = write_addr_s;
  assign if_b.write_mask = write_mask_s;
  assign if_b.write_data = write_data_s;

  rf2_masked_bypass_ram #(
    .DATAW(128), .SIZE(32), .BYPASS(1'b1), .INIT_ENABLE(1'b1), .INIT_VALUE('0)
  ) dut_a (
    .clk    (clk),
    .reset_n(reset_n),
    .bus_io (if_a.slave)
  );

  rf2_masked_bypass_ram #(
    .DATAW(128), .SIZE(20), .BYPASS(1'b0), .INIT_ENABLE(1'b1), .INIT_VALUE(InitB)
  ) dut_b (
    .clk    (clk),
    .reset_n(reset_n),
    .bus_io (if_b.slave)
  );

  int n_checks = 0;
  int n_pass = 0;

  logic [127:0] model_a [32];
  logic [127:0] model_b [20];
  logic [127:0] exp_a [$];
  logic [127:0] exp_b [$];
  logic [127:0] last_a = '0;
  logic [127:0] last_b = '0;
  bit           mon_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] req);
    n_checks++;
    if (got === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, req);
  endtask

  function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] m,
                                         input logic [127:0] d);
    return (old & ~m) | (d & m);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one accepted cycle and advance the reference model.
  task automatic issue(input bit re, input logic [4:0] ra, input bit we, input logic [4:0] wa,
                       input logic [127:0] wm, input logic [127:0] wd);
    logic [127:0] old;
    tick();
    read_en_s    = re;
    read_addr_s  = ra;
    write_en_s   = we;
    write_addr_s = wa;
    write_mask_s = wm;
    write_data_s = wd;
    if (re) begin
      old = model_a[ra];
      exp_a.push_back((we && wa == ra) ? merge(old, wm, wd) : old);
      old = '0;
      if (ra < 5'd20) old = model_b[ra];
      exp_b.push_back(old);
    end
    if (we) begin
      model_a[wa] = merge(model_a[wa], wm, wd);
      if (wa < 5'd20) model_b[wa] = merge(model_b[wa], wm, wd);
    end
  endtask

  task automatic idle();
    tick();
    read_en_s  = 1'b0;
    write_en_s = 1'b0;
  endtask

  // Unaccepted junk traffic while the sweep runs.
  task automatic junk();
    read_en_s    = 1'($urandom_range(0, 1));
    read_addr_s  = 5'($urandom_range(0, 31));
    write_en_s   = 1'b1;
    write_addr_s = 5'($urandom_range(0, 31));
    write_mask_s = Ones;
    write_data_s = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
  endtask

  // Monitor A: pop on read_valid, otherwise read_data must hold.
  always @(negedge clk) begin
    if (mon_en) begin
      if (if_a.read_valid) begin
        if (exp_a.size() == 0) begin
          n_checks++;
          $display("FAIL a_extra_valid: got read_valid=1 required no pending read");
        end else begin
          last_a = exp_a.pop_front();
          chk("a_read_data", if_a.read_data, last_a);
        end
      end else begin
        chk("a_hold", if_a.read_data, last_a);
      end
    end
  end

  // Monitor B.
  always @(negedge clk) begin
    if (mon_en) begin
      if (if_b.read_valid) begin
        if (exp_b.size() == 0) begin
          n_checks++;
          $display("FAIL b_extra_valid: got read_valid=1 required no pending read");
        end else begin
          last_b = exp_b.pop_front();
          chk("b_read_data", if_b.read_data, last_b);
        end
      end else begin
        chk("b_hold", if_b.read_data, last_b);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst_init_done_a", if_a.init_done, 0);
    chk("rst_valid_a", if_a.read_valid, 0);
    chk("rst_data_a", if_a.read_data, 0);
    chk("rst_init_done_b", if_b.init_done, 0);
    chk("rst_valid_b", if_b.read_valid, 0);
    chk("rst_data_b", if_b.read_data, 0);

    // Partial sweep, then reset mid-sweep.
    tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("early_init_done_a", if_a.init_done, 0);
      chk("early_init_done_b", if_b.init_done, 0);
      junk();
    end
    tick();
    reset_n    = 1'b0;
    read_en_s  = 1'b0;
    write_en_s = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;

    // Restarted sweep: init_done rises exactly SIZE edges after release.
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk($sformatf("sweep_a_k%0d", k), if_a.init_done, (k >= 32) ? 1 : 0);
      chk($sformatf("sweep_b_k%0d", k), if_b.init_done, (k >= 20) ? 1 : 0);
      if (k <= 15) junk();
      else begin
        read_en_s  = 1'b0;
        write_en_s = 1'b0;
      end
    end
    for (int i = 0; i < 32; i++) model_a[i] = '0;
    for (int i = 0; i < 20; i++) model_b[i] = InitB;
    mon_en = 1'b1;

    // Every entry reads back the init value; B's 20..31 read as 0.
    for (int i = 0; i < 32; i++) issue(1'b1, 5'(i), 1'b0, '0, '0, '0);
    idle();

    // Masked write to 0x0A, low 32 bits only; valid pulses once.
    issue(1'b0, '0, 1'b1, 5'h0A, {96'h0, 32'hFFFF_FFFF}, {4{32'h2}});
    issue(1'b1, 5'h0A, 1'b0, '0, '0, '0);
    idle();
    chk("mask_data_a", if_a.read_data, 128'h2);
    chk("mask_valid_a", if_a.read_valid, 1);
    idle();
    chk("mask_valid_low_a", if_a.read_valid, 0);

    // Collision on entry 5.
    issue(1'b0, '0, 1'b1, 5'd5, Ones, {32{4'h1}});
    issue(1'b1, 5'd5, 1'b1, 5'd5, {64'h0, {64{1'b1}}}, Ones);
    idle();
    chk("coll_bypass_a", if_a.read_data, 128'h1111_1111_1111_1111_FFFF_FFFF_FFFF_FFFF);
    chk("coll_old_b", if_b.read_data, {32{4'h1}});
    issue(1'b1, 5'd5, 1'b0, '0, '0, '0);
    idle();
    chk("coll_mem_a", if_a.read_data, 128'h1111_1111_1111_1111_FFFF_FFFF_FFFF_FFFF);
    chk("coll_mem_b", if_b.read_data, 128'h1111_1111_1111_1111_FFFF_FFFF_FFFF_FFFF);

    // Fill mem[i] = i, stream all addresses back, then hold.
    for (int i = 0; i < 32; i++) issue(1'b0, '0, 1'b1, 5'(i), Ones, 128'(i));
    for (int i = 0; i < 32; i++) issue(1'b1, 5'(i), 1'b0, '0, '0, '0);
    idle();
    idle();
    chk("hold_valid_a", if_a.read_valid, 0);
    chk("hold_data_a", if_a.read_data, 128'd31);
    chk("hold_data_b", if_b.read_data, 128'd0);

    // Out-of-range write/read on B; A stores it normally.
    issue(1'b0, '0, 1'b1, 5'd25, Ones, 128'hAB);
    issue(1'b1, 5'd25, 1'b0, '0, '0, '0);
    idle();
    chk("oor_data_b", if_b.read_data, 0);
    chk("oor_valid_b", if_b.read_valid, 1);
    chk("oor_data_a", if_a.read_data, 128'hAB);
    for (int i = 0; i < 20; i++) issue(1'b1, 5'(i), 1'b0, '0, '0, '0);
    idle();

    // Randomised traffic with frequent collisions.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] ra, wa;
      ra = 5'($urandom_range(0, 31));
      wa = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
      issue(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa,
            {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
      if ($urandom_range(0, 7) == 0) idle();
    end
    idle();
    idle();
    idle();
    chk("drain_a", 128'(exp_a.size()), 0);
    chk("drain_b", 128'(exp_b.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
